// File: rtl/hs_ram_arbiter.sv
// -----------------------------------------------------------------------------
// hs_ram_arbiter
//
// Hands the game's shared work-RAM port to the hiscore engine. The CPU owns
// the port by default; on hiscore intent this block requests a CPU pause,
// waits for the pause to be confirmed, lets in-flight bus cycles settle, and
// then switches the RAM port mux to the hiscore side. While the hiscore side
// owns the port, address/data/write-enable pass straight through and read
// data is captured into a register once the RAM read latency has elapsed.
//
// Ports
//   clk_sys          system clock
//   reset            synchronous, active-high reset
//   cpu_paused       CPU halted confirmation from the pause block
//   hs_address       hiscore RAM address
//   hs_data_in       hiscore write data
//   hs_write_enable  hiscore write strobe
//   hs_read_intent   hiscore wants read access
//   hs_write_intent  hiscore wants write access
//   hs_data_out      registered read data back to the hiscore engine
//   hs_ready         hiscore engine owns the port
//   hs_pause_req     pause request to the pause block
//   ram_sel          RAM port mux select (1 = hiscore side)
//   ram_addr         RAM address on the hiscore side (0 when not owned)
//   ram_din          RAM write data on the hiscore side (0 when not owned)
//   ram_we           RAM write enable (only ever 1 while owned)
//   ram_dout         RAM read data
//   abort            one-cycle pulse when ownership is lost
//
// Parameters
//   AW          RAM address width
//   DW          RAM data width
//   RD_LATENCY  RAM read latency in cycles (1..4)
//   SETTLE      settle cycles after cpu_paused before ownership (1..15)
// -----------------------------------------------------------------------------
module hs_ram_arbiter #(
    parameter int AW         = 11,
    parameter int DW         = 8,
    parameter int RD_LATENCY = 1,
    parameter int SETTLE     = 2
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          cpu_paused,
    input  logic [AW-1:0] hs_address,
    input  logic [DW-1:0] hs_data_in,
    input  logic          hs_write_enable,
    input  logic          hs_read_intent,
    input  logic          hs_write_intent,
    output logic [DW-1:0] hs_data_out,
    output logic          hs_ready,
    output logic          hs_pause_req,
    output logic          ram_sel,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout,
    output logic          abort
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SETTLE,
        S_OWN,
        S_RELEASE
    } state_t;

    state_t                state;
    logic [3:0]            settle_cnt;
    logic [RD_LATENCY-1:0] rd_vld_p;
    logic                  sel_q;

    logic intent;
    logic own;
    logic we_own;
    logic rd_launch;

    assign intent = hs_read_intent | hs_write_intent;
    assign own    = (state == S_OWN);

    // Losing cpu_paused kills the write in the very cycle it is seen, before
    // the state register has had a chance to leave OWN.
    assign we_own    = own & hs_write_enable & hs_write_intent & cpu_paused;
    assign rd_launch = own & ~we_own;

    // Reset gates the port-facing controls combinationally so the mux and
    // write strobe fall in the cycle reset is asserted, not one later.
    assign ram_we   = we_own & ~reset;
    assign ram_sel  = sel_q & ~reset;
    assign ram_addr = (own && !reset) ? hs_address : '0;
    assign ram_din  = (own && !reset) ? hs_data_in : '0;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= S_IDLE;
            settle_cnt   <= '0;
            rd_vld_p     <= '0;
            sel_q        <= 1'b0;
            hs_ready     <= 1'b0;
            hs_pause_req <= 1'b0;
            abort        <= 1'b0;
            hs_data_out  <= '0;
        end else begin
            abort <= 1'b0;

            // Read-valid pipe: a tag follows each owned read cycle and exits
            // exactly when the RAM has produced the matching data.
            rd_vld_p[0] <= rd_launch;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vld_p[i] <= rd_vld_p[i-1];
            end
            if (rd_vld_p[RD_LATENCY-1]) begin
                hs_data_out <= ram_dout;
            end

            case (state)
                S_IDLE: begin
                    if (intent) begin
                        state        <= S_REQ;
                        hs_pause_req <= 1'b1;
                    end
                end

                S_REQ: begin
                    // Mux was never switched, so release leaves ram_sel low.
                    if (!intent) begin
                        state <= S_RELEASE;
                    end else if (cpu_paused) begin
                        state      <= S_SETTLE;
                        sel_q      <= 1'b1;
                        settle_cnt <= 4'(SETTLE - 1);
                    end
                end

                S_SETTLE: begin
                    if (!cpu_paused) begin
                        state <= S_RELEASE;
                        abort <= 1'b1;
                    end else if (!intent) begin
                        state <= S_RELEASE;
                    end else if (settle_cnt == 4'd0) begin
                        state    <= S_OWN;
                        hs_ready <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                S_OWN: begin
                    // Loss of pause takes priority so a simultaneous intent
                    // drop still reports the abort.
                    if (!cpu_paused) begin
                        state    <= S_RELEASE;
                        hs_ready <= 1'b0;
                        abort    <= 1'b1;
                    end else if (!intent) begin
                        state    <= S_RELEASE;
                        hs_ready <= 1'b0;
                    end
                end

                S_RELEASE: begin
                    // Mux and pause request drop together on the way to IDLE;
                    // any new intent is picked up from IDLE next cycle.
                    state        <= S_IDLE;
                    sel_q        <= 1'b0;
                    hs_pause_req <= 1'b0;
                end

                default: begin
                    state        <= S_IDLE;
                    sel_q        <= 1'b0;
                    hs_ready     <= 1'b0;
                    hs_pause_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hs_ram_arbiter.sv
module tb_hs_ram_arbiter;

    localparam int AW = 11;
    localparam int DW = 8;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          cpu_paused;
    logic [AW-1:0] hs_address;
    logic [DW-1:0] hs_data_in;
    logic          hs_write_enable;
    logic          hs_read_intent;
    logic          hs_write_intent;
    logic [DW-1:0] hs_data_out;
    logic          hs_ready;
    logic          hs_pause_req;
    logic          ram_sel;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;
    logic          abort;

    int errors = 0;
    int checks = 0;

    always #5 clk_sys = ~clk_sys;

    hs_ram_arbiter #(.AW(AW), .DW(DW), .RD_LATENCY(1), .SETTLE(2)) dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .cpu_paused      (cpu_paused),
        .hs_address      (hs_address),
        .hs_data_in      (hs_data_in),
        .hs_write_enable (hs_write_enable),
        .hs_read_intent  (hs_read_intent),
        .hs_write_intent (hs_write_intent),
        .hs_data_out     (hs_data_out),
        .hs_ready        (hs_ready),
        .hs_pause_req    (hs_pause_req),
        .ram_sel         (ram_sel),
        .ram_addr        (ram_addr),
        .ram_din         (ram_din),
        .ram_we          (ram_we),
        .ram_dout        (ram_dout),
        .abort           (abort)
    );

    // Synchronous RAM with one cycle of read latency. Contents are loaded
    // with a fixed pattern whenever the bench reset is high.
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < (1 << AW); i++) begin
                mem[i] <= 8'(i) ^ 8'hC3;
            end
            mem[11'h123] <= 8'hA5;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_in(input logic ri, input logic wi, input logic we, input logic cp,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        hs_read_intent  = ri;
        hs_write_intent = wi;
        hs_write_enable = we;
        cpu_paused      = cp;
        hs_address      = a;
        hs_data_in      = d;
    endtask

    // Raise intent with the CPU already paused and wait (bounded) for ownership.
    task automatic get_to_own(input logic ri, input logic wi);
        int n;
        set_in(ri, wi, 1'b0, 1'b1, 11'h123, 8'h00);
        n = 0;
        while (hs_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("reach_own", hs_ready, 1'b1);
    endtask

    typedef struct {
        logic          ri, wi, we, cp;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          e_pause, e_sel, e_ready, e_we, e_abort;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        logic [DW-1:0] e_dout;
    } vec_t;

    function automatic vec_t mk(input logic ri, input logic wi, input logic we, input logic cp,
                                input logic [AW-1:0] addr, input logic [DW-1:0] din,
                                input logic e_pause, input logic e_sel, input logic e_ready,
                                input logic e_we, input logic e_abort,
                                input logic [AW-1:0] e_addr, input logic [DW-1:0] e_din,
                                input logic [DW-1:0] e_dout);
        vec_t v;
        v.ri = ri; v.wi = wi; v.we = we; v.cp = cp; v.addr = addr; v.din = din;
        v.e_pause = e_pause; v.e_sel = e_sel; v.e_ready = e_ready; v.e_we = e_we;
        v.e_abort = e_abort; v.e_addr = e_addr; v.e_din = e_din; v.e_dout = e_dout;
        return v;
    endfunction

    vec_t tbl [13];

    initial begin
        // Acquire with read intent, cpu_paused 3 cycles after the pause
        // request, two settle cycles, read 0x123, then drop intent.
        //            ri  wi  we  cp  addr    din      pau sel rdy we  abt e_addr  e_din  e_dout
        tbl[0]  = mk(1,  0,  0,  0,  11'h0,  8'h00,   0,  0,  0,  0,  0,  11'h0,  8'h00, 8'h00);
        tbl[1]  = mk(1,  0,  0,  0,  11'h0,  8'h00,   1,  0,  0,  0,  0,  11'h0,  8'h00, 8'h00);
        tbl[2]  = mk(1,  0,  0,  0,  11'h0,  8'h00,   1,  0,  0,  0,  0,  11'h0,  8'h00, 8'h00);
        tbl[3]  = mk(1,  0,  0,  0,  11'h0,  8'h00,   1,  0,  0,  0,  0,  11'h0,  8'h00, 8'h00);
        tbl[4]  = mk(1,  0,  0,  1,  11'h0,  8'h00,   1,  0,  0,  0,  0,  11'h0,  8'h00, 8'h00);
        tbl[5]  = mk(1,  0,  0,  1,  11'h0,  8'h00,   1,  1,  0,  0,  0,  11'h0,  8'h00, 8'h00);
        tbl[6]  = mk(1,  0,  1,  1,  11'h123,8'h5F,   1,  1,  0,  0,  0,  11'h0,  8'h00, 8'h00);
        tbl[7]  = mk(1,  0,  0,  1,  11'h123,8'h5F,   1,  1,  1,  0,  0,  11'h123,8'h5F, 8'h00);
        tbl[8]  = mk(1,  0,  0,  1,  11'h123,8'h5F,   1,  1,  1,  0,  0,  11'h123,8'h5F, 8'h00);
        tbl[9]  = mk(0,  0,  0,  1,  11'h123,8'h5F,   1,  1,  1,  0,  0,  11'h123,8'h5F, 8'hA5);
        tbl[10] = mk(0,  0,  0,  1,  11'h0,  8'h5F,   1,  1,  0,  0,  0,  11'h0,  8'h00, 8'hA5);
        tbl[11] = mk(0,  0,  0,  1,  11'h0,  8'h00,   0,  0,  0,  0,  0,  11'h0,  8'h00, 8'hA5);
        tbl[12] = mk(0,  0,  0,  1,  11'h0,  8'h00,   0,  0,  0,  0,  0,  11'h0,  8'h00, 8'hA5);

        reset = 1'b1;
        set_in(0, 0, 0, 0, 11'h0, 8'h00);
        repeat (3) step();
        check("rst_pause", hs_pause_req, 1'b0);
        check("rst_sel",   ram_sel,      1'b0);
        check("rst_ready", hs_ready,     1'b0);
        check("rst_we",    ram_we,       1'b0);
        check("rst_abort", abort,        1'b0);
        check("rst_dout",  hs_data_out,  8'h00);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            set_in(tbl[i].ri, tbl[i].wi, tbl[i].we, tbl[i].cp, tbl[i].addr, tbl[i].din);
            #1;
            check($sformatf("v%0d_pause", i), hs_pause_req, tbl[i].e_pause);
            check($sformatf("v%0d_sel",   i), ram_sel,      tbl[i].e_sel);
            check($sformatf("v%0d_ready", i), hs_ready,     tbl[i].e_ready);
            check($sformatf("v%0d_we",    i), ram_we,       tbl[i].e_we);
            check($sformatf("v%0d_abort", i), abort,        tbl[i].e_abort);
            check($sformatf("v%0d_addr",  i), ram_addr,     tbl[i].e_addr);
            check($sformatf("v%0d_din",   i), ram_din,      tbl[i].e_din);
            check($sformatf("v%0d_dout",  i), hs_data_out,  tbl[i].e_dout);
            step();
        end

        // Write 0x3C to 0x7FF, drop intent, observe RELEASE then IDLE.
        get_to_own(0, 1);
        set_in(0, 1, 1, 1, 11'h7FF, 8'h3C);
        #1;
        check("wr_we",   ram_we,   1'b1);
        check("wr_addr", ram_addr, 11'h7FF);
        check("wr_din",  ram_din,  8'h3C);
        step();
        check("wr_mem",  mem[11'h7FF], 8'h3C);
        set_in(0, 0, 1, 1, 11'h7FF, 8'h3C);
        step();
        check("wr_rel_we",    ram_we,       1'b0);
        check("wr_rel_sel",   ram_sel,      1'b1);
        check("wr_rel_ready", hs_ready,     1'b0);
        check("wr_rel_pause", hs_pause_req, 1'b1);
        step();
        check("wr_idle_sel",   ram_sel,      1'b0);
        check("wr_idle_pause", hs_pause_req, 1'b0);

        // Lose cpu_paused in OWN during a write: write suppressed, abort pulse.
        get_to_own(0, 1);
        set_in(0, 1, 1, 0, 11'h055, 8'hEE);
        #1;
        check("ab_we_cut",   ram_we, 1'b0);
        check("ab_pre",      abort,  1'b0);
        step();
        check("ab_pulse",    abort,    1'b1);
        check("ab_rel_sel",  ram_sel,  1'b1);
        check("ab_rel_rdy",  hs_ready, 1'b0);
        check("ab_mem",      mem[11'h055], 8'h55 ^ 8'hC3);
        set_in(0, 0, 0, 0, 11'h0, 8'h00);
        step();
        check("ab_end",      abort,        1'b0);
        check("ab_idle_sel", ram_sel,      1'b0);
        check("ab_idle_pau", hs_pause_req, 1'b0);
        step();
        check("ab_quiet",    abort,        1'b0);

        // Intent drops in REQ: no mux switch, no abort.
        set_in(1, 0, 0, 0, 11'h0, 8'h00);
        step();
        check("rq_pause", hs_pause_req, 1'b1);
        check("rq_sel",   ram_sel,      1'b0);
        set_in(0, 0, 0, 0, 11'h0, 8'h00);
        step();
        check("rq_rel_pause", hs_pause_req, 1'b1);
        check("rq_rel_sel",   ram_sel,      1'b0);
        check("rq_rel_abort", abort,        1'b0);
        step();
        check("rq_idle_pause", hs_pause_req, 1'b0);
        check("rq_idle_sel",   ram_sel,      1'b0);
        check("rq_idle_abort", abort,        1'b0);

        // Reset mid-OWN with a write in progress, then restart.
        get_to_own(0, 1);
        set_in(0, 1, 1, 1, 11'h010, 8'h77);
        #1;
        check("rs_we_before", ram_we, 1'b1);
        reset = 1'b1;
        step();
        check("rs_we",    ram_we,       1'b0);
        check("rs_sel",   ram_sel,      1'b0);
        check("rs_ready", hs_ready,     1'b0);
        check("rs_pause", hs_pause_req, 1'b0);
        check("rs_abort", abort,        1'b0);
        check("rs_addr",  ram_addr,     11'h0);
        check("rs_din",   ram_din,      8'h00);
        check("rs_dout",  hs_data_out,  8'h00);
        reset = 1'b0;
        set_in(1, 0, 0, 0, 11'h0, 8'h00);
        step();
        check("rs_req_pause", hs_pause_req, 1'b1);
        check("rs_req_sel",   ram_sel,      1'b0);
        get_to_own(1, 0);
        check("rs_own_sel",   ram_sel,      1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
